// File: rtl/pueo_beam_pkg.sv
// -----------------------------------------------------------------------------
// pueo_beam_pkg
// Shared constants and elaboration-time helpers for the beam power trigger.
//   clog2       : ceiling log2 (clog2(1) = 0)
//   offsetCorr  : constant removed from a raw channel sum to centre a beam
//   accW        : width needed to hold the largest possible window sum
//   latency     : clocks from beam_i to the P value that enters the window
//   threshT     : per-beam threshold word for the default configuration
// -----------------------------------------------------------------------------
package pueo_beam_pkg;

    // Registers between beam_i and the P value presented to the window adder:
    // beamform, square and sample-sum, then alignment padding.
    localparam int CORE_STAGES = 3;
    localparam int P_STAGES    = 7;

    function automatic int clog2(input longint value);
        int     result;
        longint v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Each channel carries v - (2^(NBITS-1) - 0.5). Summing NCHAN of them
    // (NCHAN even) gives sum(v) - offsetCorr. The same constant is also the
    // largest beam magnitude, reached at all-zeros or all-ones samples.
    function automatic longint offsetCorr(input int nChan, input int nBits);
        return longint'(nChan) * (longint'(1) << (nBits - 1)) - longint'(nChan / 2);
    endfunction

    function automatic int accW(input int nChan, input int nSamp,
                                input int nBits, input int integLen);
        longint mag;
        longint maxW;
        mag  = offsetCorr(nChan, nBits);
        maxW = longint'(integLen) * longint'(nSamp) * mag * mag;
        return clog2(maxW + 1);
    endfunction

    // P enters the window register one clock after it is formed.
    function automatic int latency();
        return P_STAGES + 1;
    endfunction

    localparam int DEF_ACC_W = accW(8, 8, 5, 2);
    typedef logic [DEF_ACC_W-1:0] threshT;

endpackage

// File: rtl/pueo_beam_power.sv
// -----------------------------------------------------------------------------
// pueo_beam_power
// One beam: forms the beam from NCHAN offset-binary channels for each of the
// NSAMP samples, squares each beam sample, sums the squares into P and keeps a
// running INTEG_LEN-clock window sum of P.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   samples   : ch c sample s at [(c*NSAMP+s)*NBITS +: NBITS]
//   windowSum : sum of the last INTEG_LEN P values; P from beam_i at cycle t
//               is included from cycle t+8 onwards
// -----------------------------------------------------------------------------
module pueo_beam_power
    import pueo_beam_pkg::*;
#(
    parameter int NCHAN     = 8,
    parameter int NSAMP     = 8,
    parameter int NBITS     = 5,
    parameter int INTEG_LEN = 2,
    parameter int ACC_W     = 18
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NCHAN*NSAMP*NBITS-1:0]   samples,
    output logic [ACC_W-1:0]               windowSum
);

    // Signed width wide enough for the raw channel sum, so the offset
    // subtraction cannot wrap.
    localparam int SW  = NBITS + clog2(NCHAN) + 1;
    localparam int QW  = 2 * SW;
    localparam int PAD = P_STAGES - CORE_STAGES;
    localparam logic signed [SW-1:0] CORR = SW'(offsetCorr(NCHAN, NBITS));

    logic [NSAMP*QW-1:0] sqFlat;
    logic [ACC_W-1:0]    sampleSum;
    logic [ACC_W-1:0]    pReg;
    logic [ACC_W-1:0]    padReg  [PAD];
    logic [ACC_W-1:0]    histReg [INTEG_LEN];
    logic [ACC_W-1:0]    windowReg;

    genvar gi;
    generate
        for (gi = 0; gi < NSAMP; gi++) begin : gSamp
            logic [SW-1:0]        chanSum;
            logic signed [SW-1:0] beamComb;
            logic signed [SW-1:0] beamReg;
            logic signed [QW-1:0] beamExt;
            logic [QW-1:0]        sqReg;

            always_comb begin
                chanSum = '0;
                for (int c = 0; c < NCHAN; c++) begin
                    chanSum = chanSum + SW'(samples[(c*NSAMP+gi)*NBITS +: NBITS]);
                end
            end

            assign beamComb = signed'(chanSum) - CORR;
            assign beamExt  = QW'(beamReg);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    beamReg <= '0;
                    sqReg   <= '0;
                end else begin
                    beamReg <= beamComb;
                    // The square of a signed SW-bit value always fits in QW bits.
                    sqReg   <= unsigned'(beamExt * beamExt);
                end
            end

            assign sqFlat[gi*QW +: QW] = sqReg;
        end
    endgenerate

    // ACC_W covers the largest possible window, so it also covers any P.
    always_comb begin
        sampleSum = '0;
        for (int s = 0; s < NSAMP; s++) begin
            sampleSum = sampleSum + ACC_W'(sqFlat[s*QW +: QW]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pReg      <= '0;
            windowReg <= '0;
            for (int i = 0; i < PAD; i++) begin
                padReg[i] <= '0;
            end
            for (int i = 0; i < INTEG_LEN; i++) begin
                histReg[i] <= '0;
            end
        end else begin
            pReg      <= sampleSum;
            padReg[0] <= pReg;
            for (int i = 1; i < PAD; i++) begin
                padReg[i] <= padReg[i-1];
            end
            histReg[0] <= padReg[PAD-1];
            for (int i = 1; i < INTEG_LEN; i++) begin
                histReg[i] <= histReg[i-1];
            end
            // The intermediate W + P may wrap ACC_W, but the result after
            // removing the oldest P never exceeds the window maximum, so
            // modular arithmetic gives the exact sum.
            windowReg <= windowReg + padReg[PAD-1] - histReg[INTEG_LEN-1];
        end
    end

    assign windowSum = windowReg;

endmodule

// File: rtl/pueo_beam_power_trigger.sv
// -----------------------------------------------------------------------------
// pueo_beam_power_trigger
// Per-beam power trigger: window sums from pueo_beam_power are compared with a
// double-buffered threshold; hits produce holdoff-limited pulses which also
// advance saturating scalers. Outputs are masked until the pipeline and
// window have filled after reset.
//   clk_i          : system clock (375 MHz)
//   rst_ni         : asynchronous active-low reset
//   beam_i         : beam b at [b*NCHAN*NSAMP*NBITS +:]
//   thresh_i       : threshold write data
//   thresh_addr_i  : shadow threshold select
//   thresh_wr_i    : write thresh_i into the selected shadow
//   update_i       : copy all shadows into the active thresholds
//   update_ack_o   : pulses in the clock the new thresholds become active
//   trigger_o      : per-beam trigger pulse
//   count_clr_i    : clear all scalers
//   count_o        : per-beam saturating trigger counts
// -----------------------------------------------------------------------------
module pueo_beam_power_trigger
    import pueo_beam_pkg::*;
#(
    parameter  int NBEAMS    = 2,
    parameter  int NCHAN     = 8,
    parameter  int NSAMP     = 8,
    parameter  int NBITS     = 5,
    parameter  int INTEG_LEN = 2,
    parameter  int HOLDOFF   = 4,
    parameter  int CNT_W     = 16,
    localparam int ACC_W     = accW(NCHAN, NSAMP, NBITS, INTEG_LEN),
    localparam int ADDR_W    = (NBEAMS > 1) ? clog2(NBEAMS) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0] beam_i,
    input  logic [ACC_W-1:0]                    thresh_i,
    input  logic [ADDR_W-1:0]                   thresh_addr_i,
    input  logic                                thresh_wr_i,
    input  logic                                update_i,
    output logic                                update_ack_o,
    output logic [NBEAMS-1:0]                   trigger_o,
    input  logic                                count_clr_i,
    output logic [NBEAMS*CNT_W-1:0]             count_o
);

    localparam int BEAM_BITS = NCHAN * NSAMP * NBITS;
    localparam int FILL      = latency() + INTEG_LEN;
    localparam int FILL_W    = clog2(FILL + 1);
    localparam int HOLD_W    = 8;

    typedef logic [ACC_W-1:0] beamThreshT;

    logic [FILL_W-1:0] fillCnt;
    logic              fillOpen;
    logic              updateAck;

    // The trigger register and the fill counter reach their final state on
    // the same edge, so trigger_o can first be high in the clock where the
    // counter saturates.
    assign fillOpen = (fillCnt >= FILL_W'(FILL - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fillCnt   <= '0;
            updateAck <= 1'b0;
        end else begin
            if (fillCnt != FILL_W'(FILL)) begin
                fillCnt <= fillCnt + FILL_W'(1);
            end
            updateAck <= update_i;
        end
    end

    assign update_ack_o = updateAck;

    genvar gi;
    generate
        for (gi = 0; gi < NBEAMS; gi++) begin : gBeam
            logic [ACC_W-1:0]  windowSum;
            beamThreshT        shadowReg;
            beamThreshT        activeReg;
            logic [HOLD_W-1:0] holdCnt;
            logic              trigReg;
            logic [CNT_W-1:0]  countReg;
            logic              hit;

            pueo_beam_power #(
                .NCHAN     (NCHAN),
                .NSAMP     (NSAMP),
                .NBITS     (NBITS),
                .INTEG_LEN (INTEG_LEN),
                .ACC_W     (ACC_W)
            ) uPower (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .samples   (beam_i[gi*BEAM_BITS +: BEAM_BITS]),
                .windowSum (windowSum)
            );

            // Addresses beyond the last beam match no instance, so such
            // writes are dropped. A simultaneous write and update loads the
            // pre-write shadow into active; the write waits for the next update.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    shadowReg <= '1;
                    activeReg <= '1;
                end else begin
                    if (thresh_wr_i && (thresh_addr_i == ADDR_W'(gi))) begin
                        shadowReg <= thresh_i;
                    end
                    if (update_i) begin
                        activeReg <= shadowReg;
                    end
                end
            end

            assign hit = (windowSum > activeReg);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    trigReg <= 1'b0;
                    holdCnt <= '0;
                end else if (fillOpen && hit && (holdCnt == '0)) begin
                    trigReg <= 1'b1;
                    holdCnt <= HOLD_W'(HOLDOFF);
                end else begin
                    trigReg <= 1'b0;
                    if (holdCnt != '0) begin
                        holdCnt <= holdCnt - HOLD_W'(1);
                    end
                end
            end

            // Clear takes priority over a coincident pulse.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    countReg <= '0;
                end else if (count_clr_i) begin
                    countReg <= '0;
                end else if (trigReg && (countReg != '1)) begin
                    countReg <= countReg + CNT_W'(1);
                end
            end

            assign trigger_o[gi]                = trigReg;
            assign count_o[gi*CNT_W +: CNT_W]   = countReg;
        end
    endgenerate

endmodule

// File: tb/tb_pueo_beam_power_trigger.sv
// -----------------------------------------------------------------------------
// tb_pueo_beam_power_trigger
// Directed and random stimulus against an arithmetic reference model of the
// beam power trigger (defaults, with a 4-bit scaler so saturation is reachable).
// -----------------------------------------------------------------------------
module tb_pueo_beam_power_trigger;

    localparam int NB   = 2;
    localparam int NC   = 8;
    localparam int NS   = 8;
    localparam int NBT  = 5;
    localparam int IL   = 2;
    localparam int HO   = 4;
    localparam int CW   = 4;
    localparam int ACCW = 18;
    localparam int FILL = 10;   // LATENCY + INTEG_LEN
    localparam int LAT  = 9;    // input cycle to trigger cycle
    localparam int HMAX = 4096;
    localparam longint ONES = (longint'(1) << ACCW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic                     clk;
    logic                     rst_n;
    logic [NB*NC*NS*NBT-1:0]  beam;
    logic [ACCW-1:0]          thresh;
    logic [0:0]               addr;
    logic                     wr;
    logic                     upd;
    logic                     ack;
    logic [NB-1:0]            trig;
    logic                     clr;
    logic [NB*CW-1:0]         cnt;

    pueo_beam_power_trigger #(
        .NBEAMS(NB), .NCHAN(NC), .NSAMP(NS), .NBITS(NBT),
        .INTEG_LEN(IL), .HOLDOFF(HO), .CNT_W(CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .beam_i        (beam),
        .thresh_i      (thresh),
        .thresh_addr_i (addr),
        .thresh_wr_i   (wr),
        .update_i      (upd),
        .update_ack_o  (ack),
        .trigger_o     (trig),
        .count_clr_i   (clr),
        .count_o       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    longint pHist [NB][HMAX];
    longint shadowM [NB];
    longint activeM [NB];
    int     lastPulse [NB];
    int     expCnt [NB];
    bit     expTrig [NB];
    bit     expAck;
    int     cyc;
    int     nVec;
    int     nMis;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        assert (got === exp) else begin
            nMis++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // P for beam b from the current inputs: each channel contributes
    // v - 15.5; doubled to stay in integers, then halved per beam sample.
    function automatic longint beamP(input int b);
        longint p;
        longint twice;
        longint bv;
        p = 0;
        for (int s = 0; s < NS; s++) begin
            twice = 0;
            for (int c = 0; c < NC; c++) begin
                twice += 2 * longint'(beam[((b*NC+c)*NS+s)*NBT +: NBT]) - 31;
            end
            bv = twice / 2;
            p += bv * bv;
        end
        return p;
    endfunction

    task automatic setConst(input int b, input int val);
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++)
                beam[((b*NC+c)*NS+s)*NBT +: NBT] = NBT'(val);
    endtask

    // nHot samples at beam value +4, the rest at beam value 0.
    task automatic setMixed(input int b, input int nHot);
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++)
                beam[((b*NC+c)*NS+s)*NBT +: NBT] =
                    (s < nHot || c < NC/2) ? NBT'(16) : NBT'(15);
    endtask

    task automatic setRandom(input int b);
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++)
                beam[((b*NC+c)*NS+s)*NBT +: NBT] = NBT'($urandom_range(0, 31));
    endtask

    task automatic modelReset();
        cyc    = 0;
        expAck = 1'b0;
        for (int b = 0; b < NB; b++) begin
            shadowM[b]   = ONES;
            activeM[b]   = ONES;
            lastPulse[b] = -1000;
            expCnt[b]    = 0;
            expTrig[b]   = 1'b0;
            for (int i = 0; i < HMAX; i++) pHist[b][i] = 0;
        end
    endtask

    // One clock: record this cycle's inputs, advance, predict and compare the
    // outputs of the following cycle, then drop the single-cycle controls.
    task automatic step();
        int     t;
        int     idx;
        longint w;
        for (int b = 0; b < NB; b++) pHist[b][cyc % HMAX] = beamP(b);
        @(posedge clk);
        #1;
        t = cyc + 1;
        for (int b = 0; b < NB; b++) begin
            if (clr) expCnt[b] = 0;
            else if (expTrig[b] && expCnt[b] < CMAX) expCnt[b]++;
            w = 0;
            for (int j = 0; j < IL; j++) begin
                idx = t - LAT - j;
                if (idx >= 0) w += pHist[b][idx % HMAX];
            end
            expTrig[b] = (t >= FILL) && (w > activeM[b]) && (t - lastPulse[b] > HO);
            if (expTrig[b]) lastPulse[b] = t;
        end
        expAck = upd;
        if (upd) for (int b = 0; b < NB; b++) activeM[b] = shadowM[b];
        if (wr && int'(addr) < NB) shadowM[addr] = longint'(thresh);
        cyc = t;
        $display("cyc %0d trig=%b ack=%b cnt=%h", cyc, trig, ack, cnt);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("trig%0d", b), 64'(trig[b]), 64'(expTrig[b]));
            chk($sformatf("cnt%0d", b), 64'(cnt[b*CW +: CW]), 64'(expCnt[b]));
        end
        chk("ack", 64'(ack), 64'(expAck));
        wr  = 1'b0;
        upd = 1'b0;
        clr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic writeThresh(input int b, input longint val);
        wr     = 1'b1;
        addr   = 1'(b);
        thresh = ACCW'(val);
        step();
    endtask

    task automatic update();
        upd = 1'b1;
        step();
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic doReset();
        rst_n = 1'b0;
        wr = 1'b0; upd = 1'b0; clr = 1'b0;
        #1;
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_ack",  64'(ack),  64'd0);
        chk("rst_cnt",  64'(cnt),  64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        nVec = 0; nMis = 0;
        rst_n = 1'b0; beam = '0; thresh = '0; addr = '0;
        wr = 1'b0; upd = 1'b0; clr = 1'b0;
        #2;

        // Defaults, all samples 16: W = 256 per beam
        setConst(0, 16); setConst(1, 16);
        doReset();
        writeThresh(0, 255);
        update();
        run(40);
        writeThresh(0, 256);
        update();
        run(20);

        // Continuous trigger to saturate the 4-bit scaler, then clear on a pulse
        writeThresh(0, 0);
        update();
        run(90);
        for (int i = 0; i < 10; i++) begin
            if (expTrig[0]) begin
                clr = 1'b1;
                step();
                break;
            end
            step();
        end
        run(7);

        // Mid-stream reset with a live scaler; fill mask restarts on release
        doReset();
        writeThresh(0, 0);
        writeThresh(1, 0);
        update();
        run(15);

        // Extremes: beam value +124 and -124, W = 246016
        setConst(0, 31); setConst(1, 0);
        writeThresh(0, 246015);
        writeThresh(1, 246016);
        update();
        run(20);
        writeThresh(0, 246016);
        writeThresh(1, 246015);
        update();
        run(20);

        // Per-beam independence: beam value +4 and -4
        setConst(0, 16); setConst(1, 15);
        writeThresh(0, 300);
        writeThresh(1, 200);
        update();
        run(20);

        // Double buffering: W0 = 64 sits between 50 and 100
        setMixed(0, 2);
        writeThresh(0, 100);
        run(12);
        wr = 1'b1; addr = 1'b0; thresh = ACCW'(50); upd = 1'b1;
        step();
        run(12);
        update();
        run(12);

        // Random samples, thresholds, updates and clears, with a reset inside
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NB; b++) setRandom(b);
            if ($urandom_range(0, 5) == 0) begin
                wr     = 1'b1;
                addr   = 1'($urandom_range(0, 1));
                thresh = ACCW'($urandom_range(6000, 16000));
            end
            if ($urandom_range(0, 7) == 0) upd = 1'b1;
            if ($urandom_range(0, 31) == 0) clr = 1'b1;
            step();
            if (i == 250) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
